// File: rtl/maj_chunk_collector.sv
// maj_chunk_collector: assembles an N-bit operand from W-bit chunks and drives it
// onto an external combinational majority block. After a settle window it samples
// the block's output and returns that sample with a popcount-based reference
// result and a mismatch flag. It also keeps a saturating count of mismatches.
module maj_chunk_collector #(
    parameter int N      = 63,
    parameter int W      = 8,
    parameter int SETTLE = 1,
    parameter int MCW    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_data,
    output logic [N-1:0]           x_out,
    input  logic                   maj_y,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_y,
    output logic                   out_ref,
    output logic [$clog2(N+1)-1:0] out_count,
    output logic                   out_mismatch,
    output logic [MCW-1:0]         mismatch_cnt
);

    localparam int NCHUNK = (N + W - 1) / W;
    localparam int CW     = $clog2(N + 1);
    localparam int SW     = NCHUNK * W;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int STW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] THRESH = CW'((N + 1) / 2);
    // Bits at positions >= N in the final chunk are padding and get dropped.
    localparam logic [SW-1:0] VMASK  = {SW{1'b1}} >> (SW - N);

    generate
        if (N % 2 == 0) begin : g_bad_n
            $error("maj_chunk_collector: N must be odd");
        end
        if (SETTLE < 1) begin : g_bad_settle
            $error("maj_chunk_collector: SETTLE must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {S_LOAD, S_SETTLE, S_RESULT} state_t;

    state_t          state, state_next;
    logic [SW-1:0]   shadow, shadow_next;
    logic [CW-1:0]   acc, acc_next;
    logic [IW-1:0]   chunk_idx;
    logic [STW-1:0]  settle_cnt;
    logic [W-1:0]    chunk_masked;
    logic            hs_in, hs_out, last_chunk, settle_done;

    function automatic logic [CW-1:0] popcnt(input logic [W-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < W; i++) c = c + CW'(v[i]);
        return c;
    endfunction

    assign hs_in       = in_valid & in_ready;
    assign hs_out      = out_valid & out_ready;
    assign last_chunk  = (chunk_idx == IW'(NCHUNK - 1));
    assign settle_done = (settle_cnt == STW'(SETTLE - 1));

    // Place the incoming chunk into the vector and count its valid ones.
    always_comb begin
        int sh;
        sh           = int'(chunk_idx) * W;
        chunk_masked = in_data & W'(VMASK >> sh);
        shadow_next  = shadow | (SW'(chunk_masked) << sh);
        acc_next     = acc + popcnt(chunk_masked);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_LOAD;
        else        state <= state_next;
    end

    // Next-state logic: LOAD -> SETTLE -> RESULT -> LOAD.
    always_comb begin
        state_next = state;
        case (state)
            S_LOAD:   if (hs_in && last_chunk) state_next = S_SETTLE;
            S_SETTLE: if (settle_done)         state_next = S_RESULT;
            S_RESULT: if (hs_out)              state_next = S_LOAD;
            default:                           state_next = S_LOAD;
        endcase
    end

    // Handshake outputs decoded from the state alone.
    always_comb begin
        in_ready  = (state == S_LOAD);
        out_valid = (state == S_RESULT);
    end

    // Datapath: vector assembly, majority sampling and result bookkeeping.
    // NOTE: the shadow vector is reset like any other register so a reset mid-load
    // cannot leak stale bits into the next vector; it is small enough to keep in flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow       <= '0;
            acc          <= '0;
            chunk_idx    <= '0;
            settle_cnt   <= '0;
            x_out        <= '0;
            out_y        <= 1'b0;
            out_ref      <= 1'b0;
            out_count    <= '0;
            out_mismatch <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (hs_in) begin
                        shadow <= shadow_next;
                        acc    <= acc_next;
                        if (last_chunk) begin
                            chunk_idx  <= '0;
                            settle_cnt <= '0;
                            x_out      <= shadow_next[N-1:0];
                            out_count  <= acc_next;
                            out_ref    <= (acc_next >= THRESH);
                        end else begin
                            chunk_idx <= chunk_idx + IW'(1);
                        end
                    end
                end
                S_SETTLE: begin
                    if (settle_done) begin
                        out_y        <= maj_y;
                        out_mismatch <= (maj_y != out_ref);
                    end else begin
                        settle_cnt <= settle_cnt + STW'(1);
                    end
                end
                S_RESULT: begin
                    if (hs_out) begin
                        shadow <= '0;
                        acc    <= '0;
                        if (out_mismatch && (mismatch_cnt != {MCW{1'b1}}))
                            mismatch_cnt <= mismatch_cnt + MCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_maj_chunk_collector.sv
// Testbench for maj_chunk_collector: directed and random vectors checked against
// a popcount reference, plus an ideal majority model that can be overridden.
module tb_maj_chunk_collector;

    localparam int N      = 63;
    localparam int W      = 8;
    localparam int NCHUNK = 8;
    localparam int CW     = 6;
    localparam int TB_MCW = 4;   // narrow counter so saturation is reachable quickly

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_data;
    logic [N-1:0]      x_out;
    logic              maj_y;
    logic              out_valid;
    logic              out_ready;
    logic              out_y;
    logic              out_ref;
    logic [CW-1:0]     out_count;
    logic              out_mismatch;
    logic [TB_MCW-1:0] mismatch_cnt;

    logic force_en  = 1'b0;
    logic force_val = 1'b0;

    int n_asserts = 0;
    int n_fail    = 0;
    int exp_mcnt  = 0;

    // Ideal majority block, optionally overridden to model a faulty block.
    assign maj_y = force_en ? force_val : ($countones(x_out) >= (N + 1) / 2);

    maj_chunk_collector #(.N(N), .W(W), .SETTLE(1), .MCW(TB_MCW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .x_out        (x_out),
        .maj_y        (maj_y),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_y        (out_y),
        .out_ref      (out_ref),
        .out_count    (out_count),
        .out_mismatch (out_mismatch),
        .mismatch_cnt (mismatch_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one chunk at a negedge and return at the negedge after it was taken.
    task automatic send_chunk(input logic [W-1:0] d);
        int to;
        to       = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && to < 50) begin
            @(negedge clk);
            to++;
        end
        if (to >= 50) chk("in_ready_wait", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = W'($urandom);
    endtask

    // Push one 64-bit chunk image through the DUT and check the whole transaction.
    task automatic run_vector(input logic [63:0] v, input logic fen, input logic fval,
                              input int bp, input bit gaps);
        logic [N-1:0] ev;
        int           ecount;
        logic         eref, ey, emm;
        ev       = v[N-1:0];
        ecount   = $countones(ev);
        eref     = (ecount >= (N + 1) / 2);
        ey       = fen ? fval : eref;
        emm      = (ey != eref);
        force_en = fen;
        force_val = fval;

        for (int k = 0; k < NCHUNK; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_chunk(v[k*W +: W]);
        end
        // Cycle t+1: vector on the majority inputs, result not yet valid.
        chk("x_out", 64'(x_out), 64'(ev));
        chk("settle_out_valid", 64'(out_valid), 64'd0);
        chk("settle_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("out_valid", 64'(out_valid), 64'd1);
        chk("out_y", 64'(out_y), 64'(ey));
        chk("out_ref", 64'(out_ref), 64'(eref));
        chk("out_count", 64'(out_count), 64'(ecount));
        chk("out_mismatch", 64'(out_mismatch), 64'(emm));

        for (int c = 0; c < bp; c++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_count", 64'(out_count), 64'(ecount));
            chk("bp_out_y", 64'(out_y), 64'(ey));
            chk("bp_out_ref", 64'(out_ref), 64'(eref));
            chk("bp_out_mismatch", 64'(out_mismatch), 64'(emm));
            chk("bp_x_out", 64'(x_out), 64'(ev));
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (emm && exp_mcnt < (1 << TB_MCW) - 1) exp_mcnt++;
        chk("post_out_valid", 64'(out_valid), 64'd0);
        chk("post_in_ready", 64'(in_ready), 64'd1);
        chk("mismatch_cnt", 64'(mismatch_cnt), 64'(exp_mcnt));
        chk("hold_x_out", 64'(x_out), 64'(ev));
        force_en = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state.
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_x_out", 64'(x_out), 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        chk("rst_mismatch_cnt", 64'(mismatch_cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // All zeros, all ones (bit 63 dropped), and the threshold boundary.
        run_vector(64'h0, 1'b0, 1'b0, 0, 1'b0);
        run_vector(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0, 1'b0);
        run_vector(64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 0, 1'b0);
        run_vector(64'h0000_0000_7FFF_FFFF, 1'b0, 1'b0, 0, 1'b0);
        run_vector(64'h8000_0000_7FFF_FFFF, 1'b0, 1'b0, 0, 1'b0);
        run_vector(64'hC000_0000_7FFF_FFFF, 1'b0, 1'b0, 0, 1'b0);

        // Backpressure with stray in_valid pulses.
        run_vector({$urandom, $urandom}, 1'b0, 1'b0, 5, 1'b0);

        // Random vectors with random gaps and backpressure.
        for (int i = 0; i < 12; i++)
            run_vector({$urandom, $urandom}, 1'b0, 1'b0, $urandom_range(0, 2), 1'b1);

        // Faulty majority block: stuck-at-1 on 31 ones, stuck-at-0 on 32 ones.
        run_vector(64'h0000_0000_7FFF_FFFF, 1'b1, 1'b1, 0, 1'b0);
        run_vector(64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0, 1, 1'b0);

        // Reset after three chunks of a new vector.
        send_chunk(8'hFF);
        send_chunk(8'hA5);
        send_chunk(8'h3C);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        exp_mcnt = 0;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_x_out", 64'(x_out), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_mismatch_cnt", 64'(mismatch_cnt), 64'd0);
        run_vector(64'h0000_0000_0000_0001, 1'b0, 1'b0, 0, 1'b0);
        run_vector({$urandom, $urandom}, 1'b0, 1'b0, 0, 1'b1);

        // Saturate the mismatch counter: 2^MCW + 3 forced mismatches.
        for (int i = 0; i < (1 << TB_MCW) + 3; i++)
            run_vector({32'h0, 1'b0, 31'h7FFF_FFFF}, 1'b1, 1'b1, 0, 1'b0);
        chk("mismatch_cnt_saturated", 64'(mismatch_cnt), 64'((1 << TB_MCW) - 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
